// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset sweep that zeroes every entry before the file is usable
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    rf_state_t         state;
    rf_state_t         state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= (state_nxt == RUN);
        end
    end

    // The last entry is written on the same edge that moves to RUN, so cnt never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with write bypass and hardware clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rR,
    output logic [NUM_RD*DATA_W-1:0] rD,
    input  logic [ADDR_W-1:0]        wR,
    input  logic [DATA_W-1:0]        wD,
    input  logic                     rf_we,
    output logic                     ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              fn_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Functional writes exist only in RUN; a pending reset also cancels them.
    assign run     = ready & ~rst;
    assign fn_we   = run & rf_we & ~((ZERO_REG != 0) && (wR == '0));

    assign wr_en   = clr_we | fn_we;
    assign wr_addr = clr_we ? clr_addr : wR;
    assign wr_data = clr_we ? '0 : wD;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = rR[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (run) begin
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    rd = '0;
                end else if (fn_we && (wR == ra)) begin
                    rd = wD;
                end else begin
                    rd = mem[ra];
                end
            end
        end

        assign rD[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp against a behavioural model
module tb_regfile_mp;

    logic        clk;
    int          checks;
    int          errors;

    // Instance A: default 32x32, 2 read ports, entry 0 hard-wired to zero
    logic        rst_a;
    logic [9:0]  rR_a;
    logic [63:0] rD_a;
    logic [4:0]  wR_a;
    logic [31:0] wD_a;
    logic        we_a;
    logic        ready_a;

    // Instance B: 64-bit x 8 entries, 4 read ports, entry 0 is ordinary storage
    logic         rst_b;
    logic [11:0]  rR_b;
    logic [255:0] rD_b;
    logic [2:0]   wR_b;
    logic [63:0]  wD_b;
    logic         we_b;
    logic         ready_b;

    logic [31:0] mdl_a [32];
    logic [63:0] mdl_b [8];
    bit          mdl_run_a;
    bit          mdl_run_b;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst_a), .rR(rR_a), .rD(rD_a),
        .wR(wR_a), .wD(wD_a), .rf_we(we_a), .ready(ready_a)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst_b), .rR(rR_b), .rD(rD_b),
        .wR(wR_b), .wD(wD_b), .rf_we(we_b), .ready(ready_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (!mdl_run_a || rst_a) return '0;
        if (a == 5'd0) return '0;
        if (we_a && wR_a == a) return wD_a;
        return mdl_a[a];
    endfunction

    function automatic logic [63:0] exp_b(input logic [2:0] a);
        if (!mdl_run_b || rst_b) return '0;
        if (we_b && wR_b == a) return wD_b;
        return mdl_b[a];
    endfunction

    task automatic chk_a_ports(input string tag);
        for (int k = 0; k < 2; k++)
            chk(tag, {32'h0, rD_a[k*32 +: 32]}, {32'h0, exp_a(rR_a[k*5 +: 5])});
    endtask

    task automatic chk_b_ports(input string tag);
        for (int k = 0; k < 4; k++)
            chk(tag, rD_b[k*64 +: 64], exp_b(rR_b[k*3 +: 3]));
    endtask

    task automatic tick_a();
        if (mdl_run_a && !rst_a && we_a && wR_a != 5'd0) mdl_a[wR_a] = wD_a;
        if (rst_a) mdl_run_a = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_b();
        if (mdl_run_b && !rst_b && we_b) mdl_b[wR_b] = wD_b;
        if (rst_b) mdl_run_b = 0;
        @(posedge clk);
        #1;
    endtask

    // Called right after rst_a is released: reads stay zero and writes are dropped for 32 edges.
    task automatic sweep_a();
        for (int i = 0; i < 32; i++) begin
            rR_a = 10'($urandom);
            we_a = 1'b1;
            wR_a = i[0] ? 5'd5 : 5'($urandom);
            wD_a = 32'hDEAD_BEEF;
            #1;
            chk_a_ports("a_clear_rd");
            @(posedge clk);
            #1;
            chk("a_clear_ready", {63'h0, ready_a}, {63'h0, (i == 31)});
        end
        we_a = 1'b0;
        for (int e = 0; e < 32; e++) mdl_a[e] = '0;
        mdl_run_a = 1;
    endtask

    task automatic sweep_b();
        for (int i = 0; i < 8; i++) begin
            rR_b = 12'($urandom);
            we_b = 1'b1;
            wR_b = 3'($urandom);
            wD_b = {$urandom, $urandom};
            #1;
            chk_b_ports("b_clear_rd");
            @(posedge clk);
            #1;
            chk("b_clear_ready", {63'h0, ready_b}, {63'h0, (i == 7)});
        end
        we_b = 1'b0;
        for (int e = 0; e < 8; e++) mdl_b[e] = '0;
        mdl_run_b = 1;
    endtask

    task automatic read_all_a(input string tag);
        for (int a = 0; a < 32; a++) begin
            rR_a = {5'(31 - a), 5'(a)};
            #1;
            chk_a_ports(tag);
        end
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        errors = 0;
        mdl_run_a = 0;
        mdl_run_b = 0;
        rst_a = 1'b1; rR_a = '0; wR_a = '0; wD_a = '0; we_a = 1'b0;
        rst_b = 1'b1; rR_b = '0; wR_b = '0; wD_b = '0; we_b = 1'b0;

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            tick_a();
            chk("a_rst_ready", {63'h0, ready_a}, 64'h0);
            chk("b_rst_ready", {63'h0, ready_b}, 64'h0);
            rR_a = 10'($urandom);
            #1;
            chk_a_ports("a_rst_rd");
        end

        rst_a = 1'b0;
        sweep_a();
        read_all_a("a_after_clear");

        // Write then read on both ports
        we_a = 1'b1; wR_a = 5'd7; wD_a = 32'h1234_5678;
        tick_a();
        we_a = 1'b0; rR_a = {5'd7, 5'd7};
        #1;
        chk("a_r7_p0", {32'h0, rD_a[31:0]}, 64'h1234_5678);
        chk("a_r7_p1", {32'h0, rD_a[63:32]}, 64'h1234_5678);

        // Same-cycle bypass
        we_a = 1'b1; wR_a = 5'd9; wD_a = 32'hA5A5_A5A5; rR_a = {5'd9, 5'd3};
        #1;
        chk("a_bypass", {32'h0, rD_a[63:32]}, 64'hA5A5_A5A5);
        chk_a_ports("a_bypass_model");
        tick_a();
        we_a = 1'b0;
        #1;
        chk("a_after_bypass", {32'h0, rD_a[63:32]}, 64'hA5A5_A5A5);

        // Zero register ignores writes and reads zero
        we_a = 1'b1; wR_a = 5'd0; wD_a = 32'hFFFF_FFFF; rR_a = {5'd0, 5'd0};
        #1;
        chk("a_zero_same", {32'h0, rD_a[31:0]}, 64'h0);
        tick_a();
        we_a = 1'b0;
        #1;
        chk("a_zero_after", {32'h0, rD_a[31:0]}, 64'h0);

        for (int i = 0; i < 300; i++) begin
            we_a = 1'($urandom);
            wR_a = 5'($urandom);
            wD_a = $urandom;
            rR_a = ($urandom_range(0, 3) == 0) ? {wR_a, wR_a} : 10'($urandom);
            #1;
            chk_a_ports("a_rand");
            tick_a();
        end
        we_a = 1'b0;
        read_all_a("a_rand_all");

        // Reset mid-clear at cnt==10
        rst_a = 1'b1;
        tick_a();
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) tick_a();
        chk("a_midclear_ready", {63'h0, ready_a}, 64'h0);
        rst_a = 1'b1;
        tick_a();
        rst_a = 1'b0;
        sweep_a();

        // Reset in RUN together with a write: reset wins, sweep restarts
        we_a = 1'b1; wR_a = 5'd3; wD_a = 32'h55;
        tick_a();
        we_a = 1'b0; rR_a = {5'd3, 5'd3};
        #1;
        chk("a_r3_written", {32'h0, rD_a[31:0]}, 64'h55);
        rst_a = 1'b1; we_a = 1'b1; wR_a = 5'd4; wD_a = 32'h77; rR_a = {5'd4, 5'd3};
        #1;
        chk_a_ports("a_rst_run_rd");
        tick_a();
        chk("a_rst_run_ready", {63'h0, ready_a}, 64'h0);
        rst_a = 1'b0; we_a = 1'b0;
        sweep_a();
        rR_a = {5'd4, 5'd3};
        #1;
        chk("a_r3_cleared", {32'h0, rD_a[31:0]}, 64'h0);
        chk("a_r4_cleared", {32'h0, rD_a[63:32]}, 64'h0);

        // Instance B: wide data, 8 entries, 4 ports, no zero register
        tick_b();
        chk("b_rst_ready2", {63'h0, ready_b}, 64'h0);
        rst_b = 1'b0;
        sweep_b();

        we_b = 1'b1; wR_b = 3'd0; wD_b = '1;
        tick_b();
        we_b = 1'b0; rR_b = '0;
        #1;
        chk("b_r0_stores", rD_b[63:0], 64'hFFFF_FFFF_FFFF_FFFF);

        for (int r = 1; r < 8; r++) begin
            we_b = 1'b1; wR_b = 3'(r); wD_b = {32'(r), 32'hC0DE_0000 + 32'(r)};
            tick_b();
        end
        we_b = 1'b0;
        rR_b = {3'd7, 3'd5, 3'd3, 3'd1};
        #1;
        chk("b_p0_r1", rD_b[63:0],    {32'd1, 32'hC0DE_0001});
        chk("b_p1_r3", rD_b[127:64],  {32'd3, 32'hC0DE_0003});
        chk("b_p2_r5", rD_b[191:128], {32'd5, 32'hC0DE_0005});
        chk("b_p3_r7", rD_b[255:192], {32'd7, 32'hC0DE_0007});
        rR_b = {3'd6, 3'd4, 3'd2, 3'd0};
        #1;
        chk_b_ports("b_even");

        for (int i = 0; i < 200; i++) begin
            we_b = 1'($urandom);
            wR_b = 3'($urandom);
            wD_b = {$urandom, $urandom};
            rR_b = 12'($urandom);
            #1;
            chk_b_ports("b_rand");
            tick_b();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
